// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: stall bus width,
// per-stage hold patterns, controller states and the redirect PC select.
package pipe_stall_ctrl_pkg;

    localparam int StallBus = 6;

    typedef logic [StallBus-1:0] stall_t;

    // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_LOAD = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EX_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // An exception outranks a simultaneous ERET, so epc is dropped in that case.
    function automatic logic [31:0] redirect_pc(input logic        excp,
                                                input logic [31:0] excp_target,
                                                input logic [31:0] epc);
        return excp ? excp_target : epc;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_stall_ctrl.
// The counter ports exist in every build and read 0 unless STALL_PERF_CNT_EN is defined.
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = StallBus,
    parameter int CNT_W   = 32
);
    // No valid/ready: the stall requests are levels and excp_req/eret_req are
    // single-cycle pulses, all sampled every clock; the outputs are always valid.
    logic               stallreq_for_load;
    logic               stallreq_for_ex;
    logic               excp_req;
    logic [31:0]        excp_target;
    logic               eret_req;
    logic [31:0]        epc;

    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        new_pc;
    logic               ex_cancel;
    logic               timeout_err;
    logic [CNT_W-1:0]   load_stall_cnt;
    logic [CNT_W-1:0]   ex_stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    state_e             state_dbg;

    modport master (
        output stallreq_for_load, stallreq_for_ex, excp_req, excp_target, eret_req, epc,
        input  stall, flush, new_pc, ex_cancel, timeout_err,
        input  load_stall_cnt, ex_stall_cnt, flush_cnt, state_dbg
    );

    modport slave (
        input  stallreq_for_load, stallreq_for_ex, excp_req, excp_target, eret_req, epc,
        output stall, flush, new_pc, ex_cancel, timeout_err,
        output load_stall_cnt, ex_stall_cnt, flush_cnt, state_dbg
    );

endinterface

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Saturating count of consecutive EX-stall cycles; expire flags the cycle in
// which the count reaches EX_TIMEOUT while the EX request is still held.
module ex_stall_watchdog #(
    parameter int EX_TIMEOUT = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic busy,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(EX_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(EX_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(EX_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(1);
        end else if (busy && count != CNT_MAX) begin
            count <= count + CW'(1);
        end
    end

    // The held cycle being counted now is the one that brings the total to EX_TIMEOUT.
    assign expire = busy && (count >= CNT_LAST);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational stall bus,
// registered flush/redirect, EX-stall watchdog. Optional counters: STALL_PERF_CNT_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W    = StallBus,
    parameter int EX_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    pipe_stall_ctrl_if.slave  bus
);
    state_e             state;
    logic               flush_q;
    logic [31:0]        new_pc_q;
    logic               ex_cancel_q;
    logic               timeout_err_q;
    logic               ex_block;
    logic [STALL_W-1:0] stall_c;
    logic               redirect;
    logic               ex_live;
    logic               wd_start;
    logic               wd_busy;
    logic               wd_expire;

    // MEM is being flushed in ST_FLUSH, so a redirect arriving then is ignored.
    assign redirect = (state != ST_FLUSH) && (bus.excp_req || bus.eret_req);
    // After a watchdog abort the stale busy level is ignored until it drops.
    assign ex_live  = bus.stallreq_for_ex && !ex_block;
    assign wd_start = (state == ST_RUN) && !redirect && ex_live;
    assign wd_busy  = (state == ST_EX_STALL) && !redirect && bus.stallreq_for_ex;

    ex_stall_watchdog #(.EX_TIMEOUT(EX_TIMEOUT)) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .start  (wd_start),
        .busy   (wd_busy),
        .clear  (!(wd_start || wd_busy)),
        .expire (wd_expire)
    );

    always_comb begin
        stall_c = STALL_W'(STALL_NONE);
        if (resetn) begin
            if (wd_start || wd_busy)
                stall_c = STALL_W'(STALL_EX);
            else if (state == ST_RUN && !redirect && bus.stallreq_for_load)
                stall_c = STALL_W'(STALL_LOAD);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_RUN;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0;
            ex_cancel_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            ex_block      <= 1'b0;
        end else begin
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0;
            ex_cancel_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            if (!bus.stallreq_for_ex)
                ex_block <= 1'b0;
            if (redirect) begin
                state       <= ST_FLUSH;
                flush_q     <= 1'b1;
                new_pc_q    <= redirect_pc(bus.excp_req, bus.excp_target, bus.epc);
                ex_cancel_q <= 1'b1;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        if (wd_start)
                            state <= ST_EX_STALL;
                    end
                    ST_EX_STALL: begin
                        if (!bus.stallreq_for_ex) begin
                            state <= ST_RUN;
                        end else if (wd_expire) begin
                            state         <= ST_RUN;
                            timeout_err_q <= 1'b1;
                            ex_cancel_q   <= 1'b1;
                            ex_block      <= 1'b1;
                        end
                    end
                    ST_FLUSH: state <= ST_RUN;
                    default:  state <= ST_RUN;
                endcase
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.flush       = flush_q;
    assign bus.new_pc      = new_pc_q;
    assign bus.ex_cancel   = ex_cancel_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.state_dbg   = state;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] load_cnt_q;
    logic [CNT_W-1:0] ex_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_cnt_q  <= '0;
            ex_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c == STALL_W'(STALL_LOAD))
                load_cnt_q <= load_cnt_q + CNT_W'(1);
            if (stall_c == STALL_W'(STALL_EX))
                ex_cnt_q <= ex_cnt_q + CNT_W'(1);
            if (flush_q)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.load_stall_cnt = load_cnt_q;
    assign bus.ex_stall_cnt   = ex_cnt_q;
    assign bus.flush_cnt      = flush_cnt_q;
`else
    assign bus.load_stall_cnt = {CNT_W{1'b0}};
    assign bus.ex_stall_cnt   = {CNT_W{1'b0}};
    assign bus.flush_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    localparam int T = 8;
    localparam logic [5:0] S_LOAD = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    pipe_stall_ctrl_if #(.STALL_W(6), .CNT_W(32)) bus ();

    pipe_stall_ctrl #(.STALL_W(6), .EX_TIMEOUT(T), .CNT_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: registered outputs due next cycle, run length of the current EX hold,
    // and whether a timed-out EX request must drop before it counts again.
    logic        nx_flush, nx_cancel, nx_terr;
    logic [31:0] nx_pc;
    int          ex_len;
    bit          blocked;
    int          m_load_cyc, m_ex_cyc, m_flush_cyc;

    logic [5:0]  exp_stall;
    logic        exp_flush, exp_cancel, exp_terr;
    logic [31:0] exp_pc;
    logic [40:0] exp_vec, act_vec;

    task automatic model_reset();
        nx_flush = 0; nx_cancel = 0; nx_terr = 0; nx_pc = 0;
        ex_len = 0; blocked = 0;
        m_load_cyc = 0; m_ex_cyc = 0; m_flush_cyc = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.stallreq_for_load = 0; bus.stallreq_for_ex = 0;
        bus.excp_req = 0; bus.excp_target = 0; bus.eret_req = 0; bus.epc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic drive(input bit ld, input bit ex, input bit ec, input logic [31:0] tg,
                         input bit er, input logic [31:0] ep);
        @(negedge clk);
        bus.stallreq_for_load = ld; bus.stallreq_for_ex = ex;
        bus.excp_req = ec; bus.excp_target = tg; bus.eret_req = er; bus.epc = ep;
        exp_flush = nx_flush; exp_pc = nx_pc; exp_cancel = nx_cancel; exp_terr = nx_terr;
        nx_flush = 0; nx_pc = 0; nx_cancel = 0; nx_terr = 0;
        if (exp_flush) begin
            exp_stall = 0; ex_len = 0;
        end else if (ec || er) begin
            exp_stall = 0; ex_len = 0;
            nx_flush = 1; nx_pc = ec ? tg : ep; nx_cancel = 1;
        end else if (ex && !blocked) begin
            exp_stall = S_EX;
            ex_len++;
            if (ex_len == T) begin
                nx_terr = 1; nx_cancel = 1; blocked = 1; ex_len = 0;
            end
        end else begin
            exp_stall = (ld && ex_len == 0) ? S_LOAD : 6'b0;
            ex_len = 0;
        end
        if (!ex) blocked = 0;
        if (exp_stall == S_LOAD) m_load_cyc++;
        if (exp_stall == S_EX)   m_ex_cyc++;
        if (exp_flush)           m_flush_cyc++;
        exp_vec = {exp_stall, exp_flush, exp_pc, exp_cancel, exp_terr};
        #2;
        act_vec = {bus.stall, bus.flush, bus.new_pc, bus.ex_cancel, bus.timeout_err};
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.state_dbg !== ST_RUN) $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_RUN);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL reset_pre_stall c%0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.stall, bus.flush, bus.new_pc, bus.ex_cancel, bus.timeout_err} !== 41'h0)
            $display("FAIL reset_mid_stall: got %h want 0",
                     {bus.stall, bus.flush, bus.new_pc, bus.ex_cancel, bus.timeout_err});
        else n_pass++;
        do_reset();
        drive(0, 0, 1, 32'h1111_2220, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (act_vec !== exp_vec) $display("FAIL reset_pre_flush: got %h want %h", act_vec, exp_vec);
        else n_pass++;
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.stall, bus.flush, bus.new_pc, bus.ex_cancel, bus.timeout_err} !== 41'h0)
            $display("FAIL reset_mid_flush: got %h want 0",
                     {bus.stall, bus.flush, bus.new_pc, bus.ex_cancel, bus.timeout_err});
        else n_pass++;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (act_vec !== 41'h0) $display("FAIL reset_release c%0d: got %h want 0", i, act_vec);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL load_use c%0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_ex_stall();
        int ex_seen = 0;
        int to_seen = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(i == 2 || i == 3, i < 5, 0, 0, 0, 0);
            if (bus.stall === S_EX) ex_seen++;
            if (bus.timeout_err === 1'b1) to_seen++;
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL ex_stall c%0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        n_checks++;
        if (ex_seen != 5 || to_seen != 0) $display("FAIL ex_stall_len: got %0d/%0d want 5/0", ex_seen, to_seen);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        int ex_seen = 0;
        int to_seen = 0;
        int load_at_to = 0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            drive(i == 8, i < 20, 0, 0, 0, 0);
            if (bus.stall === S_EX) ex_seen++;
            if (bus.timeout_err === 1'b1 && bus.ex_cancel === 1'b1) begin
                to_seen++;
                if (bus.stall === S_LOAD) load_at_to++;
            end
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL watchdog c%0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        n_checks++;
        if (ex_seen != T || to_seen != 1 || load_at_to != 1)
            $display("FAIL watchdog_summary: got ex=%0d to=%0d ld=%0d want ex=%0d to=1 ld=1",
                     ex_seen, to_seen, load_at_to, T);
        else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL redirect_pre c%0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        drive(1, 1, 1, 32'hBFC0_0380, 1, 32'h8000_1000);
        n_checks++;
        if (act_vec !== exp_vec) $display("FAIL redirect_req: got %h want %h", act_vec, exp_vec);
        else n_pass++;
        drive(1, 0, 1, 32'h1234_5678, 0, 0);
        n_checks++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'hBFC0_0380 || bus.ex_cancel !== 1'b1 || bus.stall !== 6'b0)
            $display("FAIL redirect_flush: got f=%b pc=%h c=%b s=%b want f=1 pc=bfc00380 c=1 s=000000",
                     bus.flush, bus.new_pc, bus.ex_cancel, bus.stall);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (act_vec !== 41'h0) $display("FAIL redirect_after: got %h want 0", act_vec);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 32'h8000_1000);
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'h8000_1000)
            $display("FAIL eret_redirect: got f=%b pc=%h want f=1 pc=80001000", bus.flush, bus.new_pc);
        else n_pass++;
    endtask

    task automatic test_perf();
        int e_l, e_e, e_f;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_0180, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h0000_4000);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        e_l = 3; e_e = 4; e_f = 2;
`else
        e_l = 0; e_e = 0; e_f = 0;
`endif
        n_checks++;
        if (bus.load_stall_cnt !== 32'(e_l) || bus.ex_stall_cnt !== 32'(e_e) || bus.flush_cnt !== 32'(e_f))
            $display("FAIL perf_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
                     bus.load_stall_cnt, bus.ex_stall_cnt, bus.flush_cnt, e_l, e_e, e_f);
        else n_pass++;
    endtask

    task automatic test_random();
        int ex_left = 0;
        int n_b2b = 0;
        int e_l, e_e, e_f;
        logic prev_flush = 1'b0;
        bit ld, ex, ec, er;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (ex_left == 0 && $urandom_range(0, 3) == 0) ex_left = $urandom_range(1, 12);
            ex = (ex_left > 0);
            if (ex_left > 0) ex_left--;
            ld = ($urandom_range(0, 3) == 0);
            ec = ($urandom_range(0, 19) == 0);
            er = ($urandom_range(0, 19) == 0);
            drive(ld, ex, ec, $urandom, er, $urandom);
            if (bus.flush === 1'b1 && prev_flush === 1'b1) n_b2b++;
            prev_flush = bus.flush;
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL random c%0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        n_checks++;
        if (n_b2b != 0) $display("FAIL back_to_back_flush: got %0d want 0", n_b2b);
        else n_pass++;
`ifdef STALL_PERF_CNT_EN
        e_l = m_load_cyc; e_e = m_ex_cyc; e_f = m_flush_cyc;
`else
        e_l = 0; e_e = 0; e_f = 0;
`endif
        drive(0, 0, 0, 0, 0, 0);
        if (exp_flush) e_f++;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.load_stall_cnt !== 32'(e_l) || bus.ex_stall_cnt !== 32'(e_e) || bus.flush_cnt !== 32'(e_f))
            $display("FAIL random_perf: got %0d/%0d/%0d want %0d/%0d/%0d",
                     bus.load_stall_cnt, bus.ex_stall_cnt, bus.flush_cnt, e_l, e_e, e_f);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_ex_stall();
        test_watchdog();
        test_redirect();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Sequencing controller for the 5-stage pipeline's stall/flush network. It replaces the stateless stall generator.
- Arbitrates load-use stalls, multi-cycle EX stalls and exception/ERET redirects.
- Drives the shared stall bus, a registered flush pulse and the redirect PC.
- Bounds multi-cycle EX stalls with a watchdog.
- Sits beside the pipeline stages; every stage register consumes `stall`/`flush`.

Parameters:
STALL_W, 6, stall bus width (must equal `StallBus`); bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
EX_TIMEOUT, 64, max consecutive EX-stall cycles before forced abort (>=2)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  pipeline clock
resetn  in  1  asynchronous active-low reset
stallreq_for_load  in  1  load-use hazard from ID, level
stallreq_for_ex  in  1  multi-cycle op busy in EX, level
excp_req  in  1  exception taken in MEM, single-cycle pulse
excp_target  in  32  exception vector
eret_req  in  1  ERET committing in MEM, single-cycle pulse
epc  in  32  return address for ERET
stall  out  STALL_W  per-stage hold vector
flush  out  1  registered flush of IF..MEM
new_pc  out  32  redirect PC, valid while flush=1
ex_cancel  out  1  abort in-flight multi-cycle op
timeout_err  out  1  one-cycle pulse on watchdog expiry
load_stall_cnt, ex_stall_cnt, flush_cnt  out  CNT_W each  perf counters (see Optional Feature)

Behaviour:
- Reset (async, resetn=0):
  - State RUN.
  - stall=0, flush=0, new_pc=0, ex_cancel=0, timeout_err=0.
  - Watchdog count cleared.
- States: RUN, EX_STALL, FLUSH.
- `stall` is combinational from state and inputs, so a hold takes effect in the request cycle.
- `flush`, `new_pc`, `ex_cancel` and `timeout_err` are registered.
- Priority in any cycle: excp_req > eret_req > stallreq_for_ex > stallreq_for_load.
- RUN:
  - Redirect (excp_req or eret_req) at cycle N:
    - stall=0 in cycle N.
    - Cycle N+1: flush=1; new_pc=excp_target or epc, whichever was latched at N; ex_cancel=1.
    - State -> FLUSH.
  - Else stallreq_for_ex: stall=6'b001111; state -> EX_STALL; watchdog count=1.
  - Else stallreq_for_load: stall=6'b000111 (bubble into EX); state stays RUN.
  - Else stall=0.
- EX_STALL:
  - stallreq_for_ex=1: stall=6'b001111 and count++.
  - stallreq_for_load ignored (ID already held).
  - stallreq_for_ex drops: stall=0 in that cycle; state -> RUN; count cleared.
  - Count reaches EX_TIMEOUT with request still high: stall=6'b001111 in that cycle.
    - Next cycle: timeout_err=1 and ex_cancel=1 for one cycle.
    - State -> RUN.
  - Redirect here: same as in RUN, plus ex_cancel=1; watchdog cleared.
- FLUSH:
  - Lasts exactly one cycle with flush=1 and stall=0.
  - All requests are ignored, including a new excp_req (MEM is being flushed).
  - Next state RUN; flush, new_pc and ex_cancel return to 0. new_pc returns to 0, not held.
- Simultaneous excp_req and eret_req: exception wins and epc is ignored.
- Back-to-back redirects are impossible by construction; the bench checks that none is generated.
- Reset mid-stall or mid-flush: every output is 0 immediately (async); no residual pulse after release.
- Watchdog counter width is clog2(EX_TIMEOUT+1); it saturates and never wraps.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- When defined:
  - load_stall_cnt increments each cycle a load stall is driven.
  - ex_stall_cnt increments each cycle a 6'b001111 stall is driven.
  - flush_cnt increments on each flush pulse.
  - All counters wrap modulo 2^CNT_W and clear on reset.
- When undefined: the ports remain and are tied to 0; no counter flops are synthesized.

Decomposition:
- defines.vh:
  - `StallBus`
  - stall encodings STALL_NONE=6'b000000, STALL_LOAD=6'b000111, STALL_EX=6'b001111
  - state encodings
  - default EXC vector constant
- Sub-module ex_stall_watchdog (clk, resetn, start, busy, clear, expire):
  - counter plus saturation logic
  - instantiated once

Test Plan:
- Reset: hold resetn=0 during EX_STALL with stallreq_for_ex=1 -> stall=0, flush=0, new_pc=0 immediately; after release with requests low, stall stays 0.
- Load-use: stallreq_for_load=1 for 1 cycle -> stall=6'b000111 that cycle only, then 0; no flush.
- EX stall: stallreq_for_ex high 5 cycles -> stall=6'b001111 for exactly 5 cycles; load request raised mid-way has no effect; no timeout_err.
- Watchdog: EX_TIMEOUT=8, stallreq_for_ex held 20 cycles -> stall=6'b001111 for 8 cycles; then timeout_err=1 and ex_cancel=1 for 1 cycle; state RUN; load stall honoured next cycle.
- Redirect: excp_req with excp_target=32'hBFC00380 and eret_req with epc=32'h80001000 in the same cycle, during EX_STALL -> next cycle flush=1, new_pc=32'hBFC00380, ex_cancel=1; following cycle flush=0 and stall=0.
- Perf: with STALL_PERF_CNT_EN, run 3 load stalls, 4 EX-stall cycles and 2 flushes -> counters read 3/4/2; without the macro all read 0.
